dm_bus_bridge: RTL and testbench

- Sits directly downstream of the single-cycle CPU's data-memory port (DM_CS/DM_R/DM_W, DM_addr, DM_wdata, DM_rdata).
- Converts the CPU's zero-latency memory strobes into a valid/ready request plus response bus toward a slow data RAM or peripheral fabric.
- Raises a stall so the CPU holds its PC and register writes until the access completes.
- Read data is held in a register so the CPU sees a stable value during its completing cycle.

---
 rtl/dm_bus_bridge_pkg.sv | 20 ++
 rtl/dm_bus_bridge_if.sv | 38 +++
 rtl/dm_req_latch.sv | 37 +++
 rtl/dm_bus_bridge.sv | 134 +++++++++++++
 tb/tb_dm_bus_bridge.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_bus_bridge_pkg.sv
// Shared types and constants for the CPU data-memory bus bridge.
package dm_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } dm_state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
    localparam logic [1:0]  ALIGN_MASK    = 2'b11;

    // Legal access: chip select, exactly one of read/write, word aligned.
    function automatic logic is_legal(input logic cs, input logic rd, input logic wr,
                                      input logic [1:0] addr_lo);
        return cs && (rd ^ wr) && ((addr_lo & ALIGN_MASK) == 2'b00);
    endfunction

endpackage

// File: rtl/dm_bus_bridge_if.sv
// CPU data-memory port plus downstream valid/ready bus, as seen by the bridge.
interface dm_bus_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_DM_CS;
    logic              i_DM_R;
    logic              i_DM_W;
    logic [ADDR_W-1:0] i_DM_addr;
    logic [DATA_W-1:0] i_DM_wdata;
    logic [DATA_W-1:0] o_DM_rdata;
    logic              o_stall;
    logic              o_err;
    logic              o_bus_valid;
    logic              i_bus_ready;
    logic              o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [DATA_W-1:0] o_bus_wdata;
    logic              i_bus_rvalid;
    logic [DATA_W-1:0] i_bus_rdata;

    // Environment side: CPU strobes and bus responses.
    modport master (
        output i_DM_CS, i_DM_R, i_DM_W, i_DM_addr, i_DM_wdata,
        output i_bus_ready, i_bus_rvalid, i_bus_rdata,
        input  o_DM_rdata, o_stall, o_err,
        input  o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata
    );

    // Bridge side.
    modport slave (
        input  i_DM_CS, i_DM_R, i_DM_W, i_DM_addr, i_DM_wdata,
        input  i_bus_ready, i_bus_rvalid, i_bus_rdata,
        output o_DM_rdata, o_stall, o_err,
        output o_bus_valid, o_bus_we, o_bus_addr, o_bus_wdata
    );

endinterface

// File: rtl/dm_req_latch.sv
// Request holding register: captures address, write data and direction on accept.
module dm_req_latch #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic [DATA_W-1:0] next_wdata,
    input  logic              next_we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              we
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (load) begin
            addr_q  <= next_addr;
            wdata_q <= next_wdata;
            we_q    <= next_we;
        end
    end

    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign we    = we_q;

endmodule

// File: rtl/dm_bus_bridge.sv
// Turns zero-latency CPU data-memory strobes into a valid/ready bus access and stalls the CPU.
// Define DM_BRIDGE_TIMEOUT_EN to abort bus waits after TIMEOUT_CYC cycles.
module dm_bus_bridge
    import dm_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic            inclk,
    input logic            rst,
    dm_bus_bridge_if.slave bus
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("dm_bus_bridge: DATA_W must be 32");
    end
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("dm_bus_bridge: TIMEOUT_CYC must be non-zero");
    end

    dm_state_e         state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              access, legal, illegal, timeout;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_we;

    // Strobes only count in IDLE and never while reset is held.
    assign access  = bus.i_DM_CS && !rst && (state_q == IDLE);
    assign legal   = access && is_legal(bus.i_DM_CS, bus.i_DM_R, bus.i_DM_W, bus.i_DM_addr[1:0]);
    assign illegal = access && !legal;

    dm_req_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_latch (
        .clk        (inclk),
        .rst        (rst),
        .load       (legal),
        .next_addr  (bus.i_DM_addr),
        .next_wdata (bus.i_DM_wdata),
        .next_we    (bus.i_DM_W),
        .addr       (req_addr),
        .wdata      (req_wdata),
        .we         (req_we)
    );

`ifdef DM_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Counts cycles spent in the current wait state; any state change restarts it.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == REQ) || (state_q == RESP))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (legal) begin
                    state_d = REQ;
                end else if (illegal) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            REQ: begin
                if (bus.i_bus_ready) begin
                    state_d = req_we ? DONE : RESP;
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(TIMEOUT_RDATA);
                end
            end
            RESP: begin
                if (bus.i_bus_rvalid) begin
                    state_d = DONE;
                    rdata_d = bus.i_bus_rdata;
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(TIMEOUT_RDATA);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_bus_valid = (state_q == REQ);
        bus.o_stall     = legal || (state_q == REQ) || (state_q == RESP);
        bus.o_err       = err_q;
        bus.o_DM_rdata  = illegal ? '0 : rdata_q;
        bus.o_bus_we    = req_we;
        bus.o_bus_addr  = req_addr;
        bus.o_bus_wdata = req_wdata;
    end

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Self-checking bench for dm_bus_bridge: vector table, corner sequences, randomized model check.
module tb_dm_bus_bridge;
    import dm_bus_pkg::*;

    localparam int TO_CYC = 4;
`ifdef DM_BRIDGE_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif
    localparam int BUDGET = 64;

    typedef struct {
        bit          cs;
        bit          r;
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] resp;
        int          ready_wait;
        int          rvalid_wait;
        int          exp_stall;
        int          exp_valid;
        int          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        inclk = 1'b0;
    logic        rst;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] model_rdata;

    dm_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) dm_if ();

    dm_bus_bridge #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .inclk (inclk),
        .rst   (rst),
        .bus   (dm_if)
    );

    always #5 inclk = ~inclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic cpu(input bit cs, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d);
        dm_if.i_DM_CS    = cs;
        dm_if.i_DM_R     = r;
        dm_if.i_DM_W     = w;
        dm_if.i_DM_addr  = a;
        dm_if.i_DM_wdata = d;
    endtask

    function automatic vec_t mk(input bit cs, input bit r, input bit w, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] resp,
                                input int rw, input int vw, input int es, input int ev,
                                input int ee, input logic [31:0] er);
        vec_t v;
        v.cs = cs; v.r = r; v.w = w; v.addr = addr; v.wdata = wdata; v.resp = resp;
        v.ready_wait = rw; v.rvalid_wait = vw;
        v.exp_stall = es; v.exp_valid = ev; v.exp_err = ee; v.exp_rdata = er;
        return v;
    endfunction

    // Reference: outcome of one CPU access from the bridge's contract and wait counts.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        bit legal = v.cs && (v.r != v.w) && (v.addr % 4 == 0);
        e.exp_stall = 0; e.exp_valid = 0; e.exp_err = 0;
        if (v.cs && !legal) begin
            e.exp_err   = 1;
            model_rdata = 32'h0;
        end else if (legal) begin
            if (TIMEOUT_ON && v.ready_wait >= TO_CYC) begin
                e.exp_valid = TO_CYC; e.exp_stall = TO_CYC + 1; e.exp_err = 1;
                model_rdata = 32'hDEAD_BEEF;
            end else if (v.w) begin
                e.exp_valid = v.ready_wait + 1; e.exp_stall = v.ready_wait + 2;
            end else if (TIMEOUT_ON && v.rvalid_wait >= TO_CYC) begin
                e.exp_valid = v.ready_wait + 1; e.exp_stall = v.ready_wait + 2 + TO_CYC;
                e.exp_err   = 1;
                model_rdata = 32'hDEAD_BEEF;
            end else begin
                e.exp_valid = v.ready_wait + 1;
                e.exp_stall = v.ready_wait + 3 + v.rvalid_wait;
                model_rdata = v.resp;
            end
        end
        e.exp_rdata = model_rdata;
        return e;
    endfunction

    // Entered and left at posedge+1 of an IDLE cycle; CPU holds strobes until stall drops.
    task automatic run_vec(input vec_t v, input string tag);
        int          stall_cnt = 0, valid_cnt = 0, err_cnt = 0, rcnt = 0;
        bit          accepted = 0, resp_pending = 0, done = 0, bus_ok = 1, idle_ok;
        logic [31:0] done_rdata = '0;
        cpu(v.cs, v.r, v.w, v.addr, v.wdata);
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            dm_if.i_bus_ready  = 1'b0;
            dm_if.i_bus_rvalid = 1'b0;
            if (resp_pending) begin
                if (rcnt == v.rvalid_wait) begin
                    dm_if.i_bus_rvalid = 1'b1;
                    dm_if.i_bus_rdata  = v.resp;
                    resp_pending       = 0;
                end
                rcnt++;
            end
            if (!accepted && dm_if.o_bus_valid) begin
                if (dm_if.o_bus_addr !== v.addr || dm_if.o_bus_we !== v.w) bus_ok = 0;
                if (v.w && dm_if.o_bus_wdata !== v.wdata) bus_ok = 0;
                if (valid_cnt == v.ready_wait) begin
                    dm_if.i_bus_ready = 1'b1;
                    accepted          = 1;
                    resp_pending      = v.r && !v.w;
                end
                valid_cnt++;
            end
            @(negedge inclk);
            if (dm_if.o_stall) stall_cnt++;
            else begin
                done       = 1;
                done_rdata = dm_if.o_DM_rdata;
            end
            if (dm_if.o_err) err_cnt++;
            @(posedge inclk);
            #1;
        end
        chk({tag, " complete"}, 32'(done), 32'd1);
        cpu(0, 0, 0, 32'h0, 32'h0);
        dm_if.i_bus_ready  = 1'b0;
        dm_if.i_bus_rvalid = 1'b0;
        @(negedge inclk);
        if (dm_if.o_err) err_cnt++;
        idle_ok = !dm_if.o_stall && !dm_if.o_bus_valid;
        chk({tag, " hold_rdata"}, dm_if.o_DM_rdata, v.exp_rdata);
        @(posedge inclk);
        #1;
        chk({tag, " stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
        chk({tag, " valid_cycles"}, 32'(valid_cnt), 32'(v.exp_valid));
        chk({tag, " err_pulses"}, 32'(err_cnt), 32'(v.exp_err));
        chk({tag, " done_rdata"}, done_rdata, v.exp_rdata);
        chk({tag, " bus_fields"}, 32'(bus_ok), 32'd1);
        chk({tag, " idle_after"}, 32'(idle_ok), 32'd1);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   kind;

        tbl[0] = mk(1, 0, 1, 32'h10, 32'h1234_5678, 32'h0, 0, 0, 2, 1, 0, 32'h0);
        tbl[1] = mk(1, 1, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 3, 1, 7, 4, 0, 32'hCAFE_F00D);
        tbl[2] = mk(1, 1, 0, 32'h22, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0);
        tbl[3] = mk(1, 1, 1, 32'h30, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0);
        tbl[4] = mk(1, 1, 0, 32'h50, 32'h0, 32'hA5A5_0001, 0, 0, 3, 1, 0, 32'hA5A5_0001);
        tbl[5] = mk(1, 0, 1, 32'h54, 32'hDEAD_0054, 32'h0, 2, 0, 4, 3, 0, 32'hA5A5_0001);
        tbl[6] = mk(1, 0, 0, 32'h60, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0);
        tbl[7] = mk(0, 1, 0, 32'h70, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);

        rst = 1'b1;
        cpu(0, 0, 0, 32'h0, 32'h0);
        dm_if.i_bus_ready  = 1'b0;
        dm_if.i_bus_rvalid = 1'b0;
        dm_if.i_bus_rdata  = 32'h0;
        #12;
        chk("reset stall", 32'(dm_if.o_stall), 32'd0);
        chk("reset valid", 32'(dm_if.o_bus_valid), 32'd0);
        chk("reset err", 32'(dm_if.o_err), 32'd0);
        chk("reset rdata", dm_if.o_DM_rdata, 32'h0);
        chk("reset bus_addr", dm_if.o_bus_addr, 32'h0);
        chk("reset bus_we", 32'(dm_if.o_bus_we), 32'd0);
        chk("reset bus_wdata", dm_if.o_bus_wdata, 32'h0);
        @(posedge inclk); #1;
        rst = 1'b0;
        @(posedge inclk); #1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Back-to-back: read 0x40 then write 0x44 in the first IDLE cycle after DONE.
        cpu(1, 1, 0, 32'h40, 32'h0);
        @(negedge inclk); chk("b2b rd stall", 32'(dm_if.o_stall), 32'd1);
        @(posedge inclk); #1; dm_if.i_bus_ready = 1'b1;
        @(negedge inclk); chk("b2b rd addr", dm_if.o_bus_addr, 32'h40);
        @(posedge inclk); #1;
        dm_if.i_bus_ready  = 1'b0;
        dm_if.i_bus_rvalid = 1'b1;
        dm_if.i_bus_rdata  = 32'h0BAD_CAFE;
        @(posedge inclk); #1; dm_if.i_bus_rvalid = 1'b0;
        @(negedge inclk);
        chk("b2b rd done stall", 32'(dm_if.o_stall), 32'd0);
        chk("b2b rd done rdata", dm_if.o_DM_rdata, 32'h0BAD_CAFE);
        @(posedge inclk); #1; cpu(1, 0, 1, 32'h44, 32'h55AA_1234);
        @(negedge inclk);
        chk("b2b wr stall", 32'(dm_if.o_stall), 32'd1);
        chk("b2b wr pre valid", 32'(dm_if.o_bus_valid), 32'd0);
        chk("b2b wr pre addr", dm_if.o_bus_addr, 32'h40);
        chk("b2b wr pre we", 32'(dm_if.o_bus_we), 32'd0);
        @(posedge inclk); #1; dm_if.i_bus_ready = 1'b1;
        @(negedge inclk);
        chk("b2b wr valid", 32'(dm_if.o_bus_valid), 32'd1);
        chk("b2b wr addr", dm_if.o_bus_addr, 32'h44);
        chk("b2b wr we", 32'(dm_if.o_bus_we), 32'd1);
        chk("b2b wr wdata", dm_if.o_bus_wdata, 32'h55AA_1234);
        @(posedge inclk); #1; dm_if.i_bus_ready = 1'b0;
        @(negedge inclk);
        chk("b2b wr done stall", 32'(dm_if.o_stall), 32'd0);
        chk("b2b wr keeps rdata", dm_if.o_DM_rdata, 32'h0BAD_CAFE);
        @(posedge inclk); #1; cpu(0, 0, 0, 32'h0, 32'h0);
        @(posedge inclk); #1;

`ifdef DM_BRIDGE_TIMEOUT_EN
        run_vec(mk(1, 0, 1, 32'h90, 32'h9090_9090, 32'h0, 10, 0, 5, 4, 1, 32'hDEAD_BEEF),
                "to_req");
        run_vec(mk(1, 1, 0, 32'h94, 32'h0, 32'h7777_7777, 0, 10, 6, 1, 1, 32'hDEAD_BEEF),
                "to_resp");
`endif

        // Reset while waiting for a read response; the late response must be dropped.
        cpu(1, 1, 0, 32'h80, 32'h0);
        @(posedge inclk); #1; dm_if.i_bus_ready = 1'b1;
        @(posedge inclk); #1; dm_if.i_bus_ready = 1'b0;
        @(negedge inclk);
        chk("rst resp stall", 32'(dm_if.o_stall), 32'd1);
        chk("rst resp valid", 32'(dm_if.o_bus_valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst mid valid", 32'(dm_if.o_bus_valid), 32'd0);
        chk("rst mid stall", 32'(dm_if.o_stall), 32'd0);
        chk("rst mid rdata", dm_if.o_DM_rdata, 32'h0);
        @(posedge inclk); #1; cpu(0, 0, 0, 32'h0, 32'h0); rst = 1'b0;
        @(posedge inclk); #1; dm_if.i_bus_rvalid = 1'b1; dm_if.i_bus_rdata = 32'h1111_1111;
        @(posedge inclk); #1; dm_if.i_bus_rvalid = 1'b0;
        @(negedge inclk);
        chk("rst late rdata", dm_if.o_DM_rdata, 32'h0);
        chk("rst late stall", 32'(dm_if.o_stall), 32'd0);
        chk("rst late valid", 32'(dm_if.o_bus_valid), 32'd0);
        @(posedge inclk); #1;

        model_rdata = 32'h0;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            v = mk(1, 0, 0, $urandom() & 32'h0000_FFFC, $urandom(), $urandom(),
                   $urandom_range(0, 6), $urandom_range(0, 6), 0, 0, 0, 32'h0);
            if (kind <= 3) v.r = 1;
            else if (kind <= 6) v.w = 1;
            else if (kind == 7) begin
                v.r    = 1;
                v.addr = v.addr | 32'($urandom_range(1, 3));
            end else if (kind == 8) begin
                v.r = 1;
                v.w = 1;
            end else begin
                v.cs = 0;
                v.r  = 1;
            end
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
